// File: rtl/logic_iter_ctrl.sv
// Iterative 8-bit logic engine: applies AND/OR/XOR/NOT to an accumulator
// cmd_count times, then holds the result until the consumer takes it.
module logic_iter_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] REM_ZERO = '0;
  localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             accept;

  function automatic logic [7:0] apply_op(input logic [1:0] op,
                                          input logic [7:0] acc,
                                          input logic [7:0] b);
    case (op)
      2'b00:   apply_op = acc & b;
      2'b01:   apply_op = acc | b;
      2'b10:   apply_op = acc ^ b;
      default: apply_op = ~acc;
    endcase
  endfunction

  assign accept = (state_q == S_IDLE) && cmd_valid;

  // Reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (cmd_count != REM_ZERO) ? S_RUN : S_DONE;
      S_RUN:  if (rem_q == REM_ONE) state_d = S_DONE;
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    op_d  = op_q;
    rem_d = rem_q;
    if (accept) begin
      acc_d = cmd_a;
      b_d   = cmd_b;
      op_d  = cmd_op;
      rem_d = cmd_count;
    end else if (state_q == S_RUN) begin
      acc_d = apply_op(op_q, acc_q, b_q);
      // Saturate at zero so a stray RUN cycle can never wrap the counter.
      if (rem_q != REM_ZERO) rem_d = rem_q - REM_ONE;
    end
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    res_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  assign res_data = acc_q;

endmodule
